// File: rtl/sw_sequencer.sv
// Switch-side driver for the picoMIPS core: buffers operand bytes, replays them on SW[8:0]
// with fixed setup/strobe/gap intervals and captures the LED value after each operand.
module sw_sequencer #(
    parameter int N_WORDS   = 4,
    parameter int SETUP_CYC = 4,
    parameter int HOLD_CYC  = 16,
    parameter int GAP_CYC   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [7:0]                   wr_data,
    input  logic                         start,
    input  logic [7:0]                   led,
    output logic [8:0]                   sw,
    output logic [7:0]                   result,
    output logic                         result_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         full,
    output logic [$clog2(N_WORDS+1)-1:0] count
);
    localparam int CW   = $clog2(N_WORDS + 1);
    localparam int PW   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int MAXC = (SETUP_CYC > HOLD_CYC) ?
                          ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                          ((HOLD_CYC  > GAP_CYC) ? HOLD_CYC  : GAP_CYC);
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, FINISH} state_t;

    state_t          state;
    logic [7:0]      mem [N_WORDS];
    logic [PW-1:0]   wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0]   left;
    logic [TW-1:0]   cnt;
    logic            wr_ok;

    assign wr_ok  = wr_en && (state == IDLE) && !full;
    assign rd_nxt = rd_ptr + 1'b1;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sw           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            full         <= 1'b0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            left         <= '0;
            cnt          <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                        full   <= (count == CW'(N_WORDS - 1));
                    end
                    if (start) begin
                        done <= 1'b0;
                        if (count != '0) begin
                            state <= SETUP;
                            busy  <= 1'b1;
                            sw    <= {1'b0, mem[rd_ptr]};
                            left  <= count;
                            cnt   <= TW'(SETUP_CYC - 1);
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        sw[8] <= 1'b1;
                        cnt   <= TW'(HOLD_CYC - 1);
                    end else cnt <= cnt - 1'b1;
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        sw[8] <= 1'b0;
                        cnt   <= TW'(GAP_CYC - 1);
                    end else cnt <= cnt - 1'b1;
                end
                GAP: begin
                    if (cnt == '0) begin
                        // Last gap cycle: capture the core's answer and move to the next operand.
                        result       <= led;
                        result_valid <= 1'b1;
                        rd_ptr       <= rd_nxt;
                        left         <= left - 1'b1;
                        if (left > CW'(1)) begin
                            state <= SETUP;
                            sw    <= {1'b0, mem[rd_nxt]};
                            cnt   <= TW'(SETUP_CYC - 1);
                        end else begin
                            state <= FINISH;
                            busy  <= 1'b0;
                        end
                    end else cnt <= cnt - 1'b1;
                end
                FINISH: begin
                    done   <= 1'b1;
                    count  <= '0;
                    full   <= 1'b0;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    left   <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sw_sequencer.sv
// Bench for sw_sequencer: randomized operand runs checked against interval arithmetic
// (per-operand period S+H+G) and an LED capture model.
module tb_sw_sequencer;
    localparam int N = 4, S = 4, H = 16, G = 16, P = S + H + G;

    logic       clk = 1'b0;
    logic       reset, wr_en, start;
    logic [7:0] wr_data, led;
    logic [8:0] sw;
    logic [7:0] result;
    logic       result_valid, busy, done, full;
    logic [2:0] count;

    sw_sequencer #(.N_WORDS(N), .SETUP_CYC(S), .HOLD_CYC(H), .GAP_CYC(G)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start),
        .led(led), .sw(sw), .result(result), .result_valid(result_valid),
        .busy(busy), .done(done), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin @(posedge clk); cyc++; end

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: strobe rises, strobe widths, result pulses, done edge, data stability.
    int         rise_t[$], hi_len[$], rv_t[$];
    logic [7:0] rise_d[$], rv_d[$], exp_res[$];
    int         hi_run, done_t, glitch;
    logic [8:0] sw_q = '0;
    logic       done_q = 1'b0;
    bit         led_auto = 1'b1;

    initial forever begin
        @(negedge clk);
        if (sw[8] && !sw_q[8]) begin
            rise_t.push_back(cyc);
            rise_d.push_back(sw[7:0]);
            hi_run = 0;
            if (led_auto) begin
                led = 8'($urandom);
                exp_res.push_back(led);
            end
        end
        if (sw[8]) hi_run++;
        if (!sw[8] && sw_q[8]) hi_len.push_back(hi_run);
        if (sw[8] && sw[7:0] !== sw_q[7:0]) glitch++;
        if (result_valid) begin
            rv_t.push_back(cyc);
            rv_d.push_back(result);
        end
        if (done && !done_q && done_t < 0) done_t = cyc;
        sw_q   = sw;
        done_q = done;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
    endtask

    task automatic clear_mon();
        rise_t.delete(); rise_d.delete(); hi_len.delete();
        rv_t.delete(); rv_d.delete(); exp_res.delete();
        done_t = -1; glitch = 0;
    endtask

    task automatic pulse_start(output int ts);
        start = 1'b1; tick(); start = 1'b0; ts = cyc;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin tick(); n++; end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic check_run(input string tag, input int ts, input int k, input logic [7:0] ops[$]);
        chk({tag, "_nstrobe"}, rise_t.size(), k);
        chk({tag, "_nresult"}, rv_t.size(), k);
        for (int i = 0; i < k; i++) begin
            if (i < rise_t.size()) begin
                chk({tag, "_rise_t"}, rise_t[i], ts + i * P + S);
                chk({tag, "_rise_d"}, rise_d[i], ops[i]);
            end
            if (i < hi_len.size()) chk({tag, "_hold"}, hi_len[i], H);
            if (i < rv_t.size() && i < exp_res.size()) begin
                chk({tag, "_rv_t"}, rv_t[i], ts + (i + 1) * P);
                chk({tag, "_rv_d"}, rv_d[i], exp_res[i]);
            end
        end
        chk({tag, "_done_t"}, done_t, ts + k * P + 1);
        chk({tag, "_glitch"}, glitch, 0);
        chk({tag, "_count0"}, count, 0);
        chk({tag, "_full0"},  full, 0);
        chk({tag, "_idle"},   busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ts, k, acc;
        logic [7:0] ops[$];
        logic [7:0] d;

        reset = 1'b1; wr_en = 1'b0; start = 1'b0; wr_data = '0; led = '0; done_t = -1;
        tick(2);
        chk("rst_sw", sw, 9'h000);
        chk("rst_result", result, 8'h00);
        chk("rst_rv", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        reset = 1'b0;
        tick();

        // Single operand
        clear_mon(); led_auto = 1'b0; led = 8'h3C; exp_res.push_back(8'h3C);
        write(8'hA5);
        chk("single_count", count, 1);
        pulse_start(ts);
        chk("single_sw", sw, 9'h0A5);
        chk("single_busy", busy, 1);
        wait_done(4 * P);
        ops = '{8'hA5};
        check_run("single", ts, 1, ops);
        tick();
        chk("done_holds", done, 1);

        // Back-to-back run
        clear_mon(); led_auto = 1'b1;
        write(8'h7F);
        pulse_start(ts);
        chk("b2b_done_clr", done, 0);
        chk("b2b_sw", sw, 9'h07F);
        wait_done(4 * P);
        ops = '{8'h7F};
        check_run("b2b", ts, 1, ops);

        // Full buffer, fifth write dropped
        clear_mon();
        for (int i = 1; i <= 5; i++) write(8'(i));
        chk("full_flag", full, 1);
        chk("full_count", count, 4);
        pulse_start(ts);
        wait_done(6 * P);
        ops = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_run("full", ts, 4, ops);

        // Writes and start while busy are ignored
        clear_mon(); ops.delete();
        for (int i = 0; i < 2; i++) begin d = 8'($urandom); ops.push_back(d); write(d); end
        pulse_start(ts);
        tick(S + 3);
        wr_en = 1'b1; wr_data = 8'hEE; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        chk("busy_count", count, 2);
        chk("busy_busy", busy, 1);
        wait_done(4 * P);
        check_run("busywr", ts, 2, ops);

        // LED sampling edge
        clear_mon(); led_auto = 1'b0; led = 8'h11; exp_res.push_back(8'h22);
        write(8'h5A);
        pulse_start(ts);
        tick(P - 1);
        led = 8'h22;
        tick();
        chk("edge_rv", result_valid, 1);
        chk("edge_res", result, 8'h22);
        led = 8'h33;
        tick(2);
        chk("edge_hold", result, 8'h22);
        wait_done(2 * P);
        ops = '{8'h5A};
        check_run("edge", ts, 1, ops);

        // Randomized runs
        led_auto = 1'b1;
        for (int r = 0; r < 4; r++) begin
            clear_mon(); ops.delete();
            k = $urandom_range(1, 6);
            acc = (k > N) ? N : k;
            for (int i = 0; i < k; i++) begin
                d = 8'($urandom);
                if (i < N) ops.push_back(d);
                write(d);
            end
            chk("rand_count", count, acc);
            chk("rand_full", full, (k >= N));
            pulse_start(ts);
            wait_done((acc + 2) * P);
            check_run("rand", ts, acc, ops);
        end

        // Reset mid-STROBE acts without a clock edge
        clear_mon();
        write(8'h12); write(8'h34);
        pulse_start(ts);
        tick(S + 2);
        #2 reset = 1'b1;
        #1;
        chk("mrst_sw", sw, 9'h000);
        chk("mrst_busy", busy, 0);
        chk("mrst_count", count, 0);
        chk("mrst_done", done, 0);
        chk("mrst_full", full, 0);
        tick();
        reset = 1'b0;
        tick(2);
        chk("mrst_no_rv", rv_t.size(), 0);
        pulse_start(ts);
        tick(3);
        chk("empty_start_busy", busy, 0);
        chk("empty_start_sw", sw, 9'h000);
        chk("empty_start_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sw_sequencer.md
# sw_sequencer

Programmable switch-side driver for the picoMIPS core. It buffers a short list of operand bytes and presents them one at a time on the core's 9-bit switch input: data on bits [7:0], strobe on bit 8, using fixed setup, strobe and gap intervals. After each operand it samples the core's 8-bit LED output and reports it. It sits between a bench or host controller and the core's `SW[8:0]`/`LED[7:0]` pins, running on the same divided core clock, and replaces manual switch toggling.

## Interface
- `N_WORDS`, 4: operand buffer depth, 1..16.
- `SETUP_CYC`, 4: cycles data is stable with strobe low before strobe rises, ≥1.
- `HOLD_CYC`, 16: cycles strobe (`sw[8]`) is held high, ≥1.
- `GAP_CYC`, 16: cycles strobe is low after release before LED is sampled, ≥1.

- `clk` in 1: core clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wr_en` in 1: write `wr_data` into the operand buffer.
- `wr_data` in 8: operand byte.
- `start` in 1: begin presenting buffered operands.
- `led` in 8: core LED output.
- `sw` out 9: drives core `SW[8:0]`. [8] is the strobe, [7:0] the operand.
- `result` out 8: LED value sampled after the last operand presented.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `busy` out 1: high while the sequence is running.
- `done` out 1: high from sequence completion until the next `start` or `reset`.
- `full` out 1: buffer holds `N_WORDS` entries.
- `count` out $clog2(N_WORDS+1): number of entries buffered.

## Operation
- Buffer: in-order store with a write pointer and a read pointer.
  - A write is accepted only when `wr_en`=1, the state is IDLE and `full`=0.
  - Writes while busy or full are silently dropped.
- States and transitions:
  - IDLE: `start`=1 with `count`>0 goes to SETUP. `start` with `count`=0 is ignored and the block stays IDLE.
  - SETUP: `sw[7:0]` = current entry, `sw[8]`=0, for `SETUP_CYC` cycles, then STROBE.
  - STROBE: `sw[8]`=1, `sw[7:0]` unchanged, for `HOLD_CYC` cycles, then GAP.
  - GAP: `sw[8]`=0, `sw[7:0]` unchanged, for `GAP_CYC` cycles.
  - End of GAP, last cycle: register `led` into `result`, pulse `result_valid`, advance the read pointer.
  - After GAP: go to SETUP if entries remain, otherwise go to FINISH.
  - FINISH: `done`=1, buffer emptied (pointers and `count` = 0), next state IDLE. `done` holds in IDLE.
- `start` asserted while busy is ignored.
- `start` in IDLE clears `done`.
- `busy` is 1 in SETUP, STROBE and GAP. It is 0 in IDLE and FINISH.
- The buffer is consumed by a run. Entries must be rewritten before the next `start`.
- Interval counters are wide enough for the largest of the three interval parameters.
- The counter reloads on every state entry, so each interval is exact.

## Timing
- Reset values:
  - `sw` = 9'h000, `result` = 8'h00.
  - `result_valid` = `busy` = `done` = `full` = 0, `count` = 0.
  - Buffer empty, state IDLE.
- All outputs are registered. None is combinational from inputs.
- `start` sampled at edge t:
  - `busy`=1 and `sw[7:0]` = first entry at edge t+1.
  - `sw[8]` rises at t+1+`SETUP_CYC`.
- Per operand: exactly `SETUP_CYC`+`HOLD_CYC`+`GAP_CYC` cycles.
  - `result_valid` pulses in the last GAP cycle.
  - `result` samples `led` at that edge.
- Total run for k entries is k·(S+H+G) cycles plus one FINISH cycle.
- `done` rises the cycle after the last `result_valid`.
- A write accepted at edge t is visible in `count` at t+1. `full` updates in the same cycle.
- `sw[8]` never rises in the same cycle `sw[7:0]` changes. Data is stable for ≥`SETUP_CYC` cycles before the strobe and through the whole GAP.
- Reset mid-run:
  - Immediately (asynchronously) `sw`=0, `busy`=0, `done`=0 and the buffer is cleared.
  - No `result_valid` is issued for the interrupted operand.

## Test plan
- Reset: assert `reset` mid-STROBE → `sw`=0, `busy`=0, `count`=0 immediately, without waiting for a clock edge. Then `start` without writes → stays IDLE, `busy` stays 0.
- Single operand, S=4/H=16/G=16: write 8'hA5, pulse `start`, `led` driven 8'h3C.
  - `sw[7:0]`=A5 one cycle after `start`.
  - `sw[8]` high for exactly 16 cycles starting 4 cycles later.
  - `result_valid` once with `result`=3C, 36 cycles after `sw` first shows A5.
  - `done`=1 next cycle.
- Full buffer, N_WORDS=4: write 01,02,03,04 and then 05.
  - `full`=1 and `count`=4; 05 dropped.
  - Run yields 4 strobes in order 01..04 and 4 `result_valid` pulses.
  - `count`=0 after FINISH.
- Writes and `start` while busy: issue `wr_en` and `start` during STROBE of the first of 2 operands → ignored; exactly 2 operands presented, `count` unchanged during the run.
- LED sampling edge: change `led` from 11 to 22 one cycle before the end of GAP → `result`=22. Change `led` to 33 one cycle after `result_valid` → `result` stays 22.
- Back-to-back runs: after `done`, write 7F and `start` → `done` clears the cycle after `start`, and the second run behaves identically to the single-operand case.
